// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and pipe_ctrl.
// The master side raises stall/flush requests; the slave side is the controller.
interface pipe_ctrl_if;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_count;

    modport master (
        output stallreq_from_id, stallreq_from_ex, flush_req, flush_pc,
        input  stall, flush, new_pc, stall_timeout, perf_stall_cycles, perf_flush_count
    );

    modport slave (
        input  stallreq_from_id, stallreq_from_ex, flush_req, flush_pc,
        output stall, flush, new_pc, stall_timeout, perf_stall_cycles, perf_flush_count
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with a runaway-stall watchdog.
// Define PIPE_CTRL_PERF_EN to build the saturating stall/flush performance counters.
module pipe_ctrl #(
    parameter int MAX_STALL = 64,
    parameter int CNT_W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_STALL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_STALL - 1);

    state_t           state;
    logic             flush_q;
    logic [31:0]      new_pc_q;
    logic [CNT_W-1:0] stall_cnt;
    logic             timeout_q;
    logic [5:0]       stall_vec;
    logic             stalling;

    // A pending or active flush always wins so the redirect is never held off.
    always_comb begin
        stall_vec = 6'b000000;
        if (!rst && state != FLUSH && !bus.flush_req) begin
            if (bus.stallreq_from_ex)
                stall_vec = 6'b001111;
            else if (bus.stallreq_from_id)
                stall_vec = 6'b000111;
        end
    end

    assign stalling = |stall_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            flush_q  <= 1'b0;
            new_pc_q <= 32'h0;
        end else if (bus.flush_req) begin
            state    <= FLUSH;
            flush_q  <= 1'b1;
            new_pc_q <= bus.flush_pc;
        end else begin
            flush_q <= 1'b0;
            if (state != FLUSH && (bus.stallreq_from_ex || bus.stallreq_from_id))
                state <= STALL;
            else
                state <= RUN;
        end
    end

    // Counter saturates at MAX_STALL; the flag latches on the step that reaches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else if (stalling) begin
            if (stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt >= CNT_LAST)
                timeout_q <= 1'b1;
        end else begin
            stall_cnt <= '0;
        end
    end

    assign bus.stall         = stall_vec;
    assign bus.flush         = flush_q;
    assign bus.new_pc        = new_pc_q;
    assign bus.stall_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= 32'h0;
            perf_flush_q <= 32'h0;
        end else begin
            if (stalling && perf_stall_q != 32'hFFFF_FFFF)
                perf_stall_q <= perf_stall_q + 32'd1;
            if (flush_q && perf_flush_q != 32'hFFFF_FFFF)
                perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign bus.perf_stall_cycles = perf_stall_q;
    assign bus.perf_flush_count  = perf_flush_q;
`else
    assign bus.perf_stall_cycles = 32'h0;
    assign bus.perf_flush_count  = 32'h0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a cycle model pushes expected outputs per
// driven cycle, a negedge monitor pops and compares them against the DUT.
module tb_pipe_ctrl;
    localparam int MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.MAX_STALL(MAX), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        to;
        logic [31:0] ps;
        logic [31:0] pf;
    } exp_t;

    exp_t q[$];

    // Reference state, advanced once per driven cycle.
    logic        m_flush  = 1'b0;
    logic [31:0] m_new_pc = 32'h0;
    int          m_run    = 0;
    logic        m_to     = 1'b0;
    logic [31:0] m_ps     = 32'h0;
    logic [31:0] m_pf     = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic id, input logic ex,
                        input logic fl, input logic [31:0] pc);
        exp_t e;
        @(posedge clk);
        #1;
        rst                  = r;
        bus.stallreq_from_id = id;
        bus.stallreq_from_ex = ex;
        bus.flush_req        = fl;
        bus.flush_pc         = pc;
        if (r || m_flush || fl) e.stall = 6'b000000;
        else if (ex)            e.stall = 6'b001111;
        else if (id)            e.stall = 6'b000111;
        else                    e.stall = 6'b000000;
        e.flush  = m_flush;
        e.new_pc = m_new_pc;
        e.to     = m_to;
        e.ps     = m_ps;
        e.pf     = m_pf;
        q.push_back(e);
        if (r) begin
            m_flush = 1'b0; m_new_pc = 32'h0; m_run = 0; m_to = 1'b0;
            m_ps = 32'h0; m_pf = 32'h0;
        end else begin
            m_run = (e.stall != 0) ? m_run + 1 : 0;
            if (m_run >= MAX) m_to = 1'b1;
`ifdef PIPE_CTRL_PERF_EN
            if (e.stall != 0) m_ps = m_ps + 32'd1;
            if (m_flush)      m_pf = m_pf + 32'd1;
`endif
            if (fl) m_new_pc = pc;
            m_flush = fl;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("stall",   32'(bus.stall),         32'(e.stall));
            check("flush",   32'(bus.flush),         32'(e.flush));
            check("new_pc",  bus.new_pc,             e.new_pc);
            check("timeout", 32'(bus.stall_timeout), 32'(e.to));
            check("perf_stall", bus.perf_stall_cycles, e.ps);
            check("perf_flush", bus.perf_flush_count,  e.pf);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bus.stallreq_from_id = 1'b0;
        bus.stallreq_from_ex = 1'b0;
        bus.flush_req        = 1'b0;
        bus.flush_pc         = 32'h0;
        repeat (2) @(posedge clk);

        // reset holds everything at zero even with requests asserted
        step(1, 0, 1, 1, 32'h55);
        step(1, 1, 1, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);

        // decode stall for three cycles
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 32'h0);
            @(negedge clk);
            check("id_stall_vec", 32'(bus.stall), 32'h07);
        end
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);

        // priority: ex over id, flush over both
        step(0, 1, 1, 0, 32'h0);
        step(0, 1, 1, 1, 32'h180);
        step(0, 0, 0, 0, 32'h0);
        @(negedge clk);
        check("prio_flush",  32'(bus.flush), 32'h1);
        check("prio_new_pc", bus.new_pc,     32'h180);
        step(0, 0, 0, 0, 32'h0);

        // back-to-back flush
        step(0, 0, 0, 1, 32'h100);
        step(0, 0, 0, 1, 32'h200);
        step(0, 0, 0, 0, 32'h0);
        @(negedge clk);
        check("b2b_new_pc", bus.new_pc, 32'h200);
        step(0, 0, 0, 0, 32'h0);

        // ex stall held across a one-cycle flush
        step(0, 0, 1, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);
        step(0, 0, 1, 1, 32'h300);
        step(0, 0, 1, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);
        @(negedge clk);
        check("resume_stall", 32'(bus.stall), 32'h0F);
        step(0, 0, 0, 0, 32'h0);

        // watchdog: MAX consecutive stall cycles, then sticky through flush
        for (int i = 0; i < MAX; i++) step(0, 0, 1, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        @(negedge clk);
        check("wd_set", 32'(bus.stall_timeout), 32'h1);
        step(0, 0, 0, 1, 32'h400);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        @(negedge clk);
        check("wd_sticky", 32'(bus.stall_timeout), 32'h1);

        // random traffic, then reset clears the flag
        for (int i = 0; i < 60; i++)
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), $urandom);
        step(1, 0, 1, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        @(negedge clk);
        check("wd_cleared", 32'(bus.stall_timeout), 32'h0);
        step(0, 0, 0, 0, 32'h0);

        repeat (3) @(posedge clk);
        check("drain", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline control unit for the 5-stage core. It collects stall requests from the decode and execute stages and flush requests from the exception/redirect path, and drives the per-stage `stall` vector that freezes or bubbles the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also sequences a one-cycle pipeline flush with a redirect PC, and raises a sticky timeout flag on runaway stalls.

## Interface

Parameters:
- `MAX_STALL`, default 64: consecutive stall cycles allowed before `stall_timeout` sets.
- `CNT_W`, default 8: width of the consecutive-stall counter. Must satisfy `2^CNT_W > MAX_STALL`.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `stallreq_from_id`  in  1  decode requests a hold, e.g. load-use hazard.
- `stallreq_from_ex`  in  1  execute requests a hold for a multi-cycle op.
- `flush_req`  in  1  redirect/exception flush request.
- `flush_pc`  in  32  redirect target, sampled when `flush_req` is high.
- `stall`  out  6  stage hold vector, combinational: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- `flush`  out  1  registered; clear all pipeline registers this cycle.
- `new_pc`  out  32  registered redirect PC; valid while `flush`=1.
- `stall_timeout`  out  1  sticky; set when a stall exceeds `MAX_STALL`.
- `perf_stall_cycles`  out  32  stall-cycle counter.
- `perf_flush_count`  out  32  flush counter.

## Operation

FSM states: RUN, STALL, FLUSH. State is a register and resets to RUN.

Transition priority per cycle: `flush_req` > `stallreq_from_ex` > `stallreq_from_id`.
- Any state, `flush_req`=1: go to FLUSH. Register `flush_pc` into `new_pc`.
- RUN or STALL, no flush request, any stall request: go to STALL.
- RUN or STALL, no requests: go to RUN.
- FLUSH, no `flush_req`: go to RUN. FLUSH lasts exactly one cycle unless `flush_req` is re-asserted.

Stall vector, decoded from the current inputs and state:
- State FLUSH: `stall`=6'b000000. Stall requests are ignored.
- `flush_req`=1: `stall`=6'b000000, so the flush is not blocked.
- `stallreq_from_ex`=1: `stall`=6'b001111. PC, IF, ID and EX hold; MEM receives a bubble.
- `stallreq_from_id`=1 only: `stall`=6'b000111. PC, IF and ID hold; EX receives a bubble.
- Otherwise: `stall`=6'b000000.

Flush outputs:
- `flush`=1 exactly when state is FLUSH.
- `new_pc` holds its last value otherwise.

Watchdog:
- `stall_cnt` (CNT_W bits) increments on every cycle in which `stall`≠0. It clears on any cycle with `stall`=0.
- `stall_cnt` saturates at `MAX_STALL`.
- `stall_timeout` sets on the cycle `stall_cnt` would reach `MAX_STALL`. It stays set until `rst`. A flush does not clear it.

Reset values: state RUN, `flush`=0, `new_pc`=32'h0, `stall_timeout`=0, `stall_cnt`=0, both perf counters 0. Reset overrides any in-progress stall or flush. `stall` is 0 while `rst`=1, regardless of requests.

## Timing

- `stall` has zero latency: a request at cycle t freezes the stages at the posedge ending cycle t.
- `flush` and `new_pc` have one-cycle latency: `flush_req` in cycle t gives `flush`=1 in cycle t+1.
- Back-to-back `flush_req` in cycles t and t+1 gives `flush`=1 in t+1 and t+2. `new_pc` in t+2 equals `flush_pc` from t+1.
- A stall request held across a flush: `stall`=0 during the FLUSH cycle, then the stall resumes in the following cycle. `stall_cnt` restarts from 0.
- Timeout: `stall` nonzero for `MAX_STALL` consecutive cycles gives `stall_timeout`=1 from the next cycle.

## Configuration

- Macro `PIPE_CTRL_PERF_EN`.
- Defined: `perf_stall_cycles` increments every cycle with `stall`≠0. `perf_flush_count` increments every cycle with `flush`=1. Both are 32-bit and saturate at 32'hFFFF_FFFF. Both clear only on `rst`.
- Undefined: both ports remain and are tied to 32'h0. No counter flops are synthesized.

## Test plan

- Reset: assert `rst` with `stallreq_from_ex`=1 and `flush_req`=1 -> `stall`=0, `flush`=0, `new_pc`=0, `stall_timeout`=0. After release with no requests -> all outputs remain 0.
- ID stall: `stallreq_from_id`=1 for 3 cycles -> `stall`=6'b000111 for those 3 cycles, then 0. `perf_stall_cycles`=3 with `PIPE_CTRL_PERF_EN`, 0 without.
- Priority: `stallreq_from_id`=1 and `stallreq_from_ex`=1 together -> `stall`=6'b001111. Add `flush_req`=1 with `flush_pc`=32'h0000_0180 -> `stall`=0 that cycle, `flush`=1 and `new_pc`=32'h180 next cycle.
- Back-to-back flush: `flush_req` in two consecutive cycles with `flush_pc`=32'h100 then 32'h200 -> `flush` high for 2 cycles, `new_pc` 32'h100 then 32'h200. `perf_flush_count`=2.
- Stall across flush: `stallreq_from_ex` held high, one-cycle `flush_req` -> `stall` goes 001111, 000000 (req cycle), 000000 (FLUSH), then 001111.
- Watchdog: with `MAX_STALL`=4, hold `stallreq_from_ex` for 4 cycles -> `stall_timeout`=1 from the 5th cycle. It stays 1 after the request drops and after a flush, and clears only on `rst`.
